// File: rtl/posit_pkg.sv
// Shared constants and helpers for the FP-to-posit conversion path.
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_E  = 8;
  localparam int POSIT_ES = 4;
  localparam int CNT_W    = 16;

  // Ceiling log2, never below 1 so an ID field always has at least one bit.
  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/FP_to_posit.sv
// IEEE-754 binary (N bits, E exponent bits) to posit<N,es>; purely combinational.
// Round-to-nearest-even, saturates to maxpos/minpos, Inf/NaN map to NaR.
module FP_to_posit #(
  parameter int N  = 32,
  parameter int E  = 8,
  parameter int es = 4
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  localparam int M    = N - E - 1;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int XW   = E + 2;
  localparam int BW   = 2 + es + M;
  localparam int VW   = BW + N;

  logic                 sgn;
  logic [E-1:0]         ex;
  logic [M-1:0]         mt;
  logic                 is_zero;
  logic                 is_nar;
  int                   lz;
  int                   sc_i;
  int                   k_i;
  int                   sh_i;
  logic signed [XW-1:0] sc;
  logic signed [XW-1:0] k;
  logic [es-1:0]        ebits;
  logic [M-1:0]         frac;
  logic [BW-1:0]        body;
  logic signed [VW-1:0] vec;
  logic [N-2:0]         mag;
  logic [N-2:0]         mag_r;
  logic                 guard;
  logic                 sticky;
  logic                 rnd;
  logic [N-1:0]         pos;

  assign sgn     = in[N-1];
  assign ex      = in[N-2:M];
  assign mt      = in[M-1:0];
  assign is_zero = (ex == '0) && (mt == '0);
  assign is_nar  = &ex;

  always_comb begin
    lz = M;
    for (int i = 0; i < M; i++) begin
      if (mt[i]) lz = M - 1 - i;
    end
    // Subnormals are renormalised so the hidden-one form holds for both cases.
    if (ex != '0) begin
      sc_i = int'(ex) - BIAS;
      frac = mt;
    end else begin
      sc_i = -BIAS - lz;
      frac = mt << (lz + 1);
    end
    sc    = sc_i[XW-1:0];
    k     = sc >>> es;
    ebits = sc[es-1:0];
    k_i   = int'(k);
    sh_i  = (k_i >= 0) ? k_i : (-k_i - 1);
    if (sh_i > N - 1) sh_i = N - 1;
    // Arithmetic shift replicates the leading regime bit to build the run.
    body  = {((k_i >= 0) ? 2'b10 : 2'b01), ebits, frac};
    vec   = $signed({body, {N{1'b0}}}) >>> sh_i;
    mag   = vec[VW-1 -: N-1];
    guard = vec[VW-N];
    sticky = |vec[VW-N-1:0];
    rnd   = guard & (sticky | mag[0]) & ~(&mag);
    mag_r = mag + (N-1)'(rnd);
    if (mag_r == '0) mag_r = (N-1)'(1);
    pos   = {1'b0, mag_r};
    if (is_zero)     out = '0;
    else if (is_nar) out = {1'b1, {(N-1){1'b0}}};
    else if (sgn)    out = -pos;
    else             out = pos;
  end

endmodule

// File: rtl/fp_to_posit_rr_sched.sv
// Round-robin share of one FP_to_posit among R requesters; 2-cycle latency, 1/cycle.
// Grants only when S1 can load; a stalled S2 back-pressures S1 and then all requesters.
module fp_to_posit_rr_sched
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int E  = POSIT_E,
  parameter int es = POSIT_ES,
  parameter int R  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [R-1:0]          req_valid,
  input  logic [R*N-1:0]        req_data,
  output logic [R-1:0]          req_ready,
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [log2(R)-1:0]    out_id,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      conv_count
);

  localparam int IW = log2(R);

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_data_q,  s1_data_d;
  logic [IW-1:0]    s1_id_q,    s1_id_d;
  logic [IW-1:0]    ptr_q,      ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q,  out_data_d;
  logic [IW-1:0]    out_id_q,    out_id_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             adv2;
  logic             load1;
  logic             gnt_found;
  logic [IW-1:0]    gnt_idx;
  logic [N-1:0]     conv_out;

  FP_to_posit #(.N(N), .E(E), .es(es)) u_conv (
    .in  (s1_data_q),
    .out (conv_out)
  );

  assign adv2  = s1_valid_q & (~out_valid_q | out_ready);
  assign load1 = ~s1_valid_q | adv2;

  // Scan upward from ptr with explicit wrap so non-power-of-two R works.
  always_comb begin : arb
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 0; off < R; off++) begin
      j = int'(ptr_q) + off;
      if (j >= R) j = j - R;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (load1 && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    cnt_d       = cnt_q;

    if (load1) begin
      s1_valid_d = gnt_found;
      if (gnt_found) begin
        s1_data_d = req_data[int'(gnt_idx)*N +: N];
        s1_id_d   = gnt_idx;
        ptr_d     = (gnt_idx == IW'(R - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end

    if (adv2) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_out;
      out_id_d    = s1_id_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_fp_to_posit_rr_sched.sv
// Directed bench for fp_to_posit_rr_sched: arbitration, pipeline timing, conversion, counter.
module tb_fp_to_posit_rr_sched;

  localparam int N  = 32;
  localparam int R  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [R-1:0]   req_valid = '0;
  logic [R*N-1:0] req_data = '0;
  logic [R-1:0]   req_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready = 1'b1;
  logic [15:0]    conv_count;

  int checks   = 0;
  int failures = 0;
  int grants   = 0;

  logic [31:0] vec_in  [4];
  logic [31:0] vec_exp [4];

  fp_to_posit_rr_sched #(.N(32), .E(8), .es(4), .R(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_in[0] = 32'hBF800000; vec_exp[0] = 32'hC0000000;  // -1.0
    vec_in[1] = 32'h7FC00000; vec_exp[1] = 32'h80000000;  // NaN -> NaR
    vec_in[2] = 32'h3FC00000; vec_exp[2] = 32'h41000000;  // 1.5
    vec_in[3] = 32'h3F000000; vec_exp[3] = 32'h3E000000;  // 0.5

    // Reset then idle
    do_reset();
    settle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_count", 32'(conv_count), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Single requester 2 sends 1.0
    req_data[2*N +: N] = 32'h3F800000;
    req_valid = 4'b0100;
    settle();
    check("r2_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    settle();
    check("r2_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("r2_out_valid", 32'(out_valid), 32'd1);
    check("r2_out_data", out_data, 32'h40000000);
    check("r2_out_id", 32'(out_id), 32'd2);
    step();
    check("r2_drained", 32'(out_valid), 32'd0);
    check("r2_count", 32'(conv_count), 32'd1);

    // All four valid, streaming: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < R; i++) req_data[i*N +: N] = 32'h40000000;
    req_valid = 4'hF;
    for (int c = 0; c <= 6; c++) begin
      settle();
      if (c <= 5) check($sformatf("rot_ready_c%0d", c), 32'(req_ready), 32'd1 << (c % 4));
      if (c >= 2) begin
        check($sformatf("rot_valid_c%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("rot_id_c%0d", c), 32'(out_id), 32'((c - 2) % 4));
        check($sformatf("rot_data_c%0d", c), out_data, 32'h42000000);
      end
      if (c == 6) req_valid = '0;
      step();
    end
    step();
    check("rot_drained", 32'(out_valid), 32'd0);
    check("rot_count", 32'(conv_count), 32'd6);

    // Full stall with out_ready low for 5 cycles
    do_reset();
    out_ready = 1'b0;
    req_data[0*N +: N] = 32'h3F800000;
    req_data[1*N +: N] = 32'h40000000;
    req_data[2*N +: N] = 32'h40800000;
    req_data[3*N +: N] = 32'hBF800000;
    req_valid = 4'hF;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      settle();
      grants += $countones(req_valid & req_ready);
      if (c >= 2) begin
        check($sformatf("stall_ready_c%0d", c), 32'(req_ready), 32'd0);
        check($sformatf("stall_id_c%0d", c), 32'(out_id), 32'd0);
      end
      step();
    end
    check("stall_grants", 32'(grants), 32'd2);
    out_ready = 1'b1;
    settle();
    check("release_ready", 32'(req_ready), 32'h4);
    check("release_id0", 32'(out_id), 32'd0);
    check("release_data0", out_data, 32'h40000000);
    step();
    req_valid = '0;
    settle();
    check("release_id1", 32'(out_id), 32'd1);
    check("release_data1", out_data, 32'h42000000);
    step();
    check("release_id2", 32'(out_id), 32'd2);
    check("release_data2", out_data, 32'h44000000);
    step();
    check("release_drained", 32'(out_valid), 32'd0);

    // Zero operand from requester 1
    req_data[1*N +: N] = 32'h00000000;
    req_valid = 4'b0010;
    settle();
    check("zero_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_data", out_data, 32'd0);
    check("zero_id", 32'(out_id), 32'd1);

    // Fill both stages, then reset mid-operation
    out_ready = 1'b0;
    req_valid = 4'hF;
    settle();
    check("fill_ready", 32'(req_ready), 32'h4);
    step();
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_ready", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_rst_valid_c%0d", c), 32'(out_valid), 32'd0);
    end
    check("post_rst_count", 32'(conv_count), 32'd0);

    // Conversion vectors through requester 3
    for (int v = 0; v < 4; v++) begin
      req_data[3*N +: N] = vec_in[v];
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      step();
      check($sformatf("vec%0d_data", v), out_data, vec_exp[v]);
      check($sformatf("vec%0d_id", v), 32'(out_id), 32'd3);
      step();
    end

    // Counter saturation
    do_reset();
    req_data[0*N +: N] = 32'h3F800000;
    req_valid = 4'b0001;
    repeat (65536) step();
    check("sat_before", 32'(conv_count), 32'h0000FFFE);
    step();
    check("sat_reach", 32'(conv_count), 32'h0000FFFF);
    repeat (2) step();
    check("sat_hold", 32'(conv_count), 32'h0000FFFF);
    check("sat_data", out_data, 32'h40000000);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_to_posit_rr_sched.md
# fp_to_posit_rr_sched

Round-robin scheduler that shares one `FP_to_posit` converter between `R` IEEE-754 single-precision requesters. Each requester has a valid/ready port. The block grants one request per cycle and registers the granted operand and its requester ID ahead of the combinational converter. A registered output stage carries the posit result and that ID to a single downstream consumer under backpressure. It sits between the FP producers (load/issue logic) and the posit arithmetic units.

## Interface
Parameters:
- `N`, 32, word width of both the FP input and the posit output
- `E`, 8, FP exponent width, passed to the converter
- `es`, 4, posit exponent field width, passed to the converter
- `R`, 4, number of requesters (2..16)
- `IW`, log2(R), ID width; computed from `R`, not overridden

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `req_valid`  in  R  request present, one bit per requester
- `req_data`  in  R*N  FP operands; requester i occupies bits [i*N +: N]
- `req_ready`  out  R  one-hot or zero; bit i high means requester i is accepted this cycle
- `out_valid`  out  1  result present
- `out_data`  out  N  posit result
- `out_id`  out  IW  index of the requester that issued the result
- `out_ready`  in  1  consumer accepts the result this cycle
- `conv_count`  out  16  count of delivered results, saturating

## Operation
- Two register stages:
  - S1 holds `s1_valid`, `s1_data` and `s1_id`.
  - The `FP_to_posit` converter sits combinationally between S1 and S2.
  - S2 holds `out_valid`, `out_data` and `out_id`.
- Stage-enable signals:
  - `adv2` = `s1_valid` & (!`out_valid` | `out_ready`).
  - `load1` = !`s1_valid` | `adv2`.
- Grant rules:
  - Grant is evaluated only when `load1` is high.
  - The search starts at pointer `ptr`, scans upward modulo R, and picks the first i with `req_valid[i]`=1.
  - `req_ready[i]` goes high for that i only; it is combinational from `req_valid`, `ptr` and `load1`.
  - When `load1` is low, `req_ready` = 0.
- On handshake (`req_valid[g]` & `req_ready[g]`):
  - S1 loads `req_data[g]` and `g`.
  - `s1_valid` <= 1.
  - `ptr` <= (g+1) mod R. When R is not a power of two, the wrap is explicit.
- Cycle with `load1`=1 and no requester valid: `s1_valid` <= `adv2` ? 0 : `s1_valid`, and `ptr` holds.
- When `adv2`=1:
  - S2 loads the converter output and `s1_id`.
  - `out_valid` <= 1.
- When `out_valid` & `out_ready` and `adv2`=0: `out_valid` <= 0.
- `conv_count` increments on each `out_valid` & `out_ready` and saturates at 16'hFFFF.
- Data in S1/S2 is held stable while its stage is stalled. The converter input changes only on an S1 load.
- Requesters must hold `req_data` and `req_valid` until accepted. The block does not latch unaccepted requests.

## Timing
- Reset (async assert, sync release):
  - `s1_valid`=0, `out_valid`=0.
  - `out_data`=0, `out_id`=0.
  - `ptr`=0, `conv_count`=0.
  - `req_ready`=0 follows combinationally, because `load1`=1 but no valid is sampled until release.
- Latency: a request accepted at edge t with downstream free gives `out_valid`=1 after edge t+1. That is 2 cycles from `req_valid` high to `out_valid`, with no idle cycles.
- Throughput: 1 result per cycle while `out_ready`=1.
- Full stall: with S1 and S2 both valid and `out_ready`=0, all `req_ready`=0, and S1/S2 and `ptr` hold.
- Simultaneous drain and fill: with `out_ready`=1 while full, S2 takes S1, S1 takes a new grant, and `ptr` advances in the same cycle.
- Fairness: with all R requesters continuously valid, grants rotate 0,1,…,R-1,0. No requester waits more than R-1 grants.
- Reset mid-operation: in-flight S1/S2 contents are discarded, and no result for them is ever emitted.

## Structure
- Shared package `posit_pkg`:
  - defaults `N`/`E`/`es`
  - the `log2` function used for `IW`
  - the count width constant (16)
- One sub-module: the existing `FP_to_posit` (params `N`, `E`, `es`; ports `in`, `out`), instantiated once as `u_conv`.
- Arbitration is implemented in-line. No separate arbiter module.

## Test plan
- Reset then idle: `out_valid`=0, `req_ready`=0, `conv_count`=0.
- Requester 2 only, data 32'h3F800000 (1.0) -> 2 cycles later `out_data`=32'h40000000, `out_id`=2.
- All 4 valid, `out_ready`=1, requester i sends 32'h40000000 (2.0) -> `out_id` sequence 0,1,2,3,0, each `out_data`=32'h42000000, one result per cycle.
- `out_ready`=0 for 5 cycles with all requesters valid -> exactly 2 grants (R0, R1), then `req_ready`=0. On release, results arrive in order R0, R1, R2.
- Requester 1 sends 32'h00000000 -> `out_data`=0, `out_id`=1. Assert `rst_n`=0 with both stages full -> both valid flags clear immediately and no stale output follows.
- Force 65535 deliveries plus 2 more -> `conv_count`=16'hFFFF and it holds.
